bitseq_loader: RTL and testbench
================================

# bitseq_loader

Upstream feeder for the single-channel bit-sequence player. Accepts a packed byte stream (valid/ready, LSB-first bits) from the host/command path and unpacks it into one-bit-per-cycle writes on the player's sequence-memory port. Latches the sequence length it presents to the player and optionally fires the player's start pulse once the load completes. Enforces the no-write-while-playing rule on its own side.

## Interface
- `AW`, 8, player memory address width; sequence depth 2^AW bits
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `load_req`  in  1  one-cycle pulse; begin a load of `load_len` bits
- `load_len`  in  AW+1  bit count, legal 1..2^AW; sampled on accepted `load_req`
- `auto_start`  in  1  sampled with `load_req`; fire `start_trig` on success
- `abort`  in  1  synchronous cancel of an in-progress load
- `s_valid`  in  1  byte-stream valid
- `s_ready`  out  1  byte-stream ready
- `s_data`  in  8  packed bits; bit 0 is written first
- `s_last`  in  1  marks the final byte of the sequence
- `playing`  in  1  player busy indicator
- `wr_en`  out  1  player memory write enable
- `wr_addr`  out  AW  player memory write address
- `wr_bit`  out  1  player memory write data
- `len_out`  out  AW+1  committed sequence length to the player
- `start_trig`  out  1  one-cycle start pulse to the player
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse on successful completion
- `err`  out  1  sticky error; cleared by the next accepted `load_req`

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- **IDLE**
  - `load_req` with legal `load_len` and `playing`=0: latch length and `auto_start`, clear `bit_cnt` and `err`, go to WAIT_BYTE.
  - `load_req` with `load_len`=0, `load_len`>2^AW, or `playing`=1: set `err`, stay in IDLE, no writes.
- **WAIT_BYTE**
  - `s_ready`=1.
  - On `s_valid`&&`s_ready`: latch `s_data` and `s_last`, set `k`=0, go to SHIFT.
- **SHIFT**
  - `s_ready`=0.
  - Each cycle: `wr_en`=1, `wr_addr`=`bit_cnt[AW-1:0]`, `wr_bit`=`byte[k]`; then increment `bit_cnt` and `k`.
  - Stop at `k`=7 or `bit_cnt`=len-1. Excess bits in the final byte are discarded.
  - If all bits were written and `s_last` was set, go to DONE.
  - If bits remain and `s_last` was clear, go to WAIT_BYTE.
  - Mismatch (all bits written without `s_last`, or `s_last` with bits remaining): set `err`, go to IDLE. No `done`, no `start_trig`, `len_out` unchanged.
- **DONE**
  - One cycle: `done`=1, `len_out`=latched length, `start_trig`=latched `auto_start`.
  - Then go to IDLE.
- `busy`=1 in WAIT_BYTE, SHIFT and DONE.
- `load_req` outside IDLE is ignored.
- `abort` in any non-IDLE state: go to IDLE next cycle, `wr_en` drops immediately, `err` is not set. `abort` wins over a simultaneous `load_req` or byte handshake.
- `playing` rising while `busy`: set `err`, go to IDLE. No write is issued in that cycle.
- Counter widths:
  - `bit_cnt` is AW+1 bits; the length compare uses the full width.
  - `k` is 3 bits.

## Timing
- Reset values: `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_bit`=0, `len_out`=0, `start_trig`=0, `busy`=0, `done`=0, `err`=0; state is IDLE.
- Reset mid-load abandons the load; the memory contents already written are undefined for reuse.
- All outputs are registered.
- `load_req` accepted at cycle 0: `s_ready`=1 from cycle 1.
- Byte accepted at cycle n: writes occur in cycles n+1..n+8 (fewer for a final partial byte).
- Throughput: 9 cycles per byte minimum. No overlap of `s_ready` with SHIFT.
- DONE follows the cycle after the last write. `done`, `start_trig` and the new `len_out` are visible in the same cycle, so the player samples a length that is already stable.
- `s_data`/`s_last` are only sampled on the handshake cycle. `s_valid` may drop without penalty.

## Structure
- Shared package `bitseq_pkg`:
  - state enum `bitseq_ld_state_t` (IDLE/WAIT_BYTE/SHIFT/DONE)
  - constant `BITSEQ_BYTE_W`=8
- Single flat module, no sub-module. Loader and player are connected in the separate channel wrapper.

## Test plan
- **Two-byte load:** AW=8, `load_len`=12, `auto_start`=1, bytes 0xA5 (`last`=0) then 0x0F (`last`=1) -> writes to addr 0..11 with bits 1,0,1,0,0,1,0,1,1,1,1,1; then `done`=`start_trig`=1 for one cycle; `len_out`=12.
- **Illegal requests:** `load_len`=0, then `load_len`=257 -> `err`=1 each time; `s_ready` stays 0; no `wr_en`; `busy`=0.
- **Early `s_last`:** `load_len`=12, first byte 0xFF with `s_last`=1 -> 8 writes (addr 0..7), then `err`=1, IDLE, no `done`, `len_out` holds its prior value.
- **Backpressure:** `s_valid` low for 5 cycles in WAIT_BYTE -> `s_ready` held at 1, no writes, `bit_cnt` unchanged; the subsequent byte is written normally.
- **`playing` interlock:** `playing`=1 at `load_req` -> `err`, no writes. `playing` rising at the 3rd SHIFT cycle -> `wr_en`=0 from that cycle, `err`=1, IDLE.
- **Full depth, abort, reset:** `load_len`=256 over 32 bytes -> last write at addr 255, `len_out`=256. `abort` mid-SHIFT -> IDLE next cycle with `err`=0. `rst_n` low mid-load -> all outputs at reset values.

Source files
------------

// File: rtl/bitseq_pkg.sv
// rtl/bitseq_pkg.sv - shared types and constants for the bit-sequence loader
package bitseq_pkg;

    localparam int BITSEQ_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        DONE
    } bitseq_ld_state_t;

endpackage

// File: rtl/bitseq_loader.sv
// rtl/bitseq_loader.sv - unpacks an LSB-first byte stream into one-bit writes for the sequence player
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_req/load_len          start a load of load_len bits (1..2^AW)
//   auto_start                 fire start_trig when the load completes
//   abort                      cancel an in-progress load without error
//   s_valid/s_ready/s_data/s_last   packed byte stream, bit 0 first
//   playing                    player busy; loads are refused while high
//   wr_en/wr_addr/wr_bit       player sequence-memory write port
//   len_out/start_trig         committed length and start pulse to the player
//   busy/done/err              status: in progress, success pulse, sticky error
module bitseq_loader
    import bitseq_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_req,
    input  logic [AW:0]              load_len,
    input  logic                     auto_start,
    input  logic                     abort,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BITSEQ_BYTE_W-1:0] s_data,
    input  logic                     s_last,
    input  logic                     playing,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic                     wr_bit,
    output logic [AW:0]              len_out,
    output logic                     start_trig,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    bitseq_ld_state_t state, nxt_state;

    logic [AW:0]              len_r, nxt_len;
    logic [AW:0]              bit_cnt, nxt_cnt;
    logic                     auto_r, nxt_auto;
    logic [2:0]               k, nxt_k;
    logic [BITSEQ_BYTE_W-1:0] byte_r, nxt_byte;
    logic                     last_r, nxt_last;

    logic                     nxt_wr_en;
    logic [AW-1:0]            nxt_wr_addr;
    logic                     nxt_wr_bit;
    logic [AW:0]              nxt_len_out;
    logic                     nxt_err;

    logic len_ok;
    logic last_bit;
    logic final_bit;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    // bit_cnt indexes the bit being written during SHIFT
    assign last_bit  = (bit_cnt == len_r - ONE);
    assign final_bit = (k == 3'd7) || last_bit;

    always_comb begin
        nxt_state   = state;
        nxt_len     = len_r;
        nxt_cnt     = bit_cnt;
        nxt_auto    = auto_r;
        nxt_k       = k;
        nxt_byte    = byte_r;
        nxt_last    = last_r;
        nxt_wr_en   = 1'b0;
        nxt_wr_addr = wr_addr;
        nxt_wr_bit  = wr_bit;
        nxt_len_out = len_out;
        nxt_err     = err;

        case (state)
            IDLE: begin
                if (load_req) begin
                    if (len_ok && !playing) begin
                        nxt_len   = load_len;
                        nxt_auto  = auto_start;
                        nxt_cnt   = '0;
                        nxt_err   = 1'b0;
                        nxt_state = WAIT_BYTE;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            WAIT_BYTE: begin
                if (s_valid && s_ready) begin
                    nxt_byte    = s_data;
                    nxt_last    = s_last;
                    nxt_k       = 3'd0;
                    // first write of the byte is registered on the handshake edge
                    nxt_wr_en   = 1'b1;
                    nxt_wr_addr = bit_cnt[AW-1:0];
                    nxt_wr_bit  = s_data[0];
                    nxt_state   = SHIFT;
                end
            end
            SHIFT: begin
                nxt_cnt = bit_cnt + ONE;
                nxt_k   = k + 3'd1;
                if (!final_bit) begin
                    nxt_wr_en   = 1'b1;
                    nxt_wr_addr = nxt_cnt[AW-1:0];
                    nxt_wr_bit  = byte_r[nxt_k];
                end else if (last_bit && last_r) begin
                    nxt_len_out = len_r;
                    nxt_state   = DONE;
                end else if (!last_bit && !last_r) begin
                    nxt_state = WAIT_BYTE;
                end else begin
                    nxt_err   = 1'b1;
                    nxt_state = IDLE;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        // abort outranks everything, then the playing interlock
        if (state != IDLE) begin
            if (abort) begin
                nxt_state   = IDLE;
                nxt_wr_en   = 1'b0;
                nxt_len_out = len_out;
                nxt_err     = err;
            end else if (playing) begin
                nxt_state   = IDLE;
                nxt_wr_en   = 1'b0;
                nxt_len_out = len_out;
                nxt_err     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_r      <= '0;
            bit_cnt    <= '0;
            auto_r     <= 1'b0;
            k          <= 3'd0;
            byte_r     <= '0;
            last_r     <= 1'b0;
            s_ready    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_bit     <= 1'b0;
            len_out    <= '0;
            start_trig <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt_state;
            len_r      <= nxt_len;
            bit_cnt    <= nxt_cnt;
            auto_r     <= nxt_auto;
            k          <= nxt_k;
            byte_r     <= nxt_byte;
            last_r     <= nxt_last;
            s_ready    <= (nxt_state == WAIT_BYTE);
            wr_en      <= nxt_wr_en;
            wr_addr    <= nxt_wr_addr;
            wr_bit     <= nxt_wr_bit;
            len_out    <= nxt_len_out;
            start_trig <= (nxt_state == DONE) && auto_r;
            busy       <= (nxt_state != IDLE);
            done       <= (nxt_state == DONE);
            err        <= nxt_err;
        end
    end

endmodule

// File: tb/tb_bitseq_loader.sv
// tb/tb_bitseq_loader.sv - directed self-checking bench for bitseq_loader
module tb_bitseq_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_req = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          auto_start = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          playing = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_bit;
    logic [AW:0]   len_out;
    logic          start_trig;
    logic          busy;
    logic          done;
    logic          err;

    int tests = 0;
    int fails = 0;

    bitseq_loader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_len(load_len),
        .auto_start(auto_start), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .playing(playing), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_bit(wr_bit), .len_out(len_out), .start_trig(start_trig),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int hs_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_valid && s_ready) hs_cyc <= cyc;
    end

    bit wr_seen [0:255];
    bit wr_val  [0:255];
    int wr_count, last_addr, first_wr_cyc, last_wr_cyc;
    int done_count, trig_count, len_at_done, done_cyc;
    bit mon_clr = 1'b1;

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int i = 0; i < 256; i++) begin
                wr_seen[i] = 1'b0;
                wr_val[i]  = 1'b0;
            end
            wr_count = 0; last_addr = -1; first_wr_cyc = -1; last_wr_cyc = -1;
            done_count = 0; trig_count = 0; len_at_done = -1; done_cyc = -1;
        end else begin
            if (wr_en) begin
                if (wr_count == 0) first_wr_cyc = cyc;
                wr_seen[wr_addr] = 1'b1;
                wr_val[wr_addr]  = wr_bit;
                wr_count++;
                last_addr   = int'(wr_addr);
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_count++;
                len_at_done = int'(len_out);
                done_cyc    = cyc;
            end
            if (start_trig) trig_count++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_load(input int len, input bit auto_v);
        load_req   = 1'b1;
        load_len   = (AW+1)'(len);
        auto_start = auto_v;
        tick();
        load_req   = 1'b0;
        auto_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b required 0", wr_en); end
        tests++; if ({wr_addr, wr_bit} !== '0) begin fails++; $display("FAIL rst_wr_port: got %h required 0", {wr_addr, wr_bit}); end
        tests++; if (len_out !== '0) begin fails++; $display("FAIL rst_len_out: got %0d required 0", len_out); end
        tests++; if ({start_trig, busy, done, err} !== 4'b0) begin fails++; $display("FAIL rst_status: got %b required 0000", {start_trig, busy, done, err}); end
        rst_n = 1'b1;
        tick();
        clr_mon();
    endtask

    task automatic test_two_byte();
        logic [11:0] exp_bits = 12'hFA5;
        int h1;
        clr_mon();
        do_load(12, 1'b1);
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL two_ready_after_req: got %b required 1", s_ready); end
        send_byte(8'hA5, 1'b0);
        h1 = hs_cyc;
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL two_ready_in_shift: got %b required 0", s_ready); end
        send_byte(8'h0F, 1'b1);
        wait_idle(40);
        tests++; if (first_wr_cyc != h1 + 1) begin fails++; $display("FAIL two_first_wr_cycle: got %0d required %0d", first_wr_cyc, h1 + 1); end
        tests++; if (wr_count != 12) begin fails++; $display("FAIL two_wr_count: got %0d required 12", wr_count); end
        for (int a = 0; a < 12; a++) begin
            tests++;
            if (!(wr_seen[a] == 1'b1 && wr_val[a] == exp_bits[a])) begin
                fails++; $display("FAIL two_bit_%0d: got seen=%b val=%b required seen=1 val=%b", a, wr_seen[a], wr_val[a], exp_bits[a]);
            end
        end
        tests++; if (done_count != 1 || trig_count != 1) begin fails++; $display("FAIL two_done_trig: got done=%0d trig=%0d required 1/1", done_count, trig_count); end
        tests++; if (len_at_done != 12) begin fails++; $display("FAIL two_len_at_done: got %0d required 12", len_at_done); end
        tests++; if (done_cyc != last_wr_cyc + 1) begin fails++; $display("FAIL two_done_cycle: got %0d required %0d", done_cyc, last_wr_cyc + 1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL two_err: got %b required 0", err); end
    endtask

    task automatic test_illegal();
        clr_mon();
        do_load(0, 1'b0);
        tests++; if ({err, s_ready, busy} !== 3'b100) begin fails++; $display("FAIL illegal_len0: got err/ready/busy=%b required 100", {err, s_ready, busy}); end
        tick();
        do_load(257, 1'b0);
        tests++; if ({err, s_ready, busy} !== 3'b100) begin fails++; $display("FAIL illegal_len257: got err/ready/busy=%b required 100", {err, s_ready, busy}); end
        tick(); tick(); tick();
        tests++; if (wr_count != 0 || s_ready !== 1'b0) begin fails++; $display("FAIL illegal_no_writes: got writes=%0d ready=%b required 0/0", wr_count, s_ready); end
        tests++; if (len_out !== 9'd12) begin fails++; $display("FAIL illegal_len_out: got %0d required 12", len_out); end
    endtask

    task automatic test_early_last();
        clr_mon();
        do_load(12, 1'b1);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL early_err_cleared: got %b required 0", err); end
        send_byte(8'hFF, 1'b1);
        wait_idle(40);
        tests++; if (wr_count != 8 || last_addr != 7) begin fails++; $display("FAIL early_writes: got count=%0d last=%0d required 8/7", wr_count, last_addr); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL early_err: got %b required 1", err); end
        tests++; if (done_count != 0 || trig_count != 0) begin fails++; $display("FAIL early_no_done: got done=%0d trig=%0d required 0/0", done_count, trig_count); end
        tests++; if (len_out !== 9'd12) begin fails++; $display("FAIL early_len_out: got %0d required 12", len_out); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b = 8'h3C;
        clr_mon();
        do_load(8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (s_ready !== 1'b1 || wr_count != 0) begin
                fails++; $display("FAIL bp_hold_%0d: got ready=%b writes=%0d required 1/0", i, s_ready, wr_count);
            end
        end
        send_byte(b, 1'b1);
        wait_idle(40);
        tests++; if (wr_count != 8) begin fails++; $display("FAIL bp_wr_count: got %0d required 8", wr_count); end
        for (int a = 0; a < 8; a++) begin
            tests++;
            if (!(wr_seen[a] == 1'b1 && wr_val[a] == b[a])) begin
                fails++; $display("FAIL bp_bit_%0d: got seen=%b val=%b required seen=1 val=%b", a, wr_seen[a], wr_val[a], b[a]);
            end
        end
        tests++; if (done_count != 1 || trig_count != 0) begin fails++; $display("FAIL bp_done_trig: got done=%0d trig=%0d required 1/0", done_count, trig_count); end
        tests++; if (len_out !== 9'd8) begin fails++; $display("FAIL bp_len_out: got %0d required 8", len_out); end
    endtask

    task automatic test_playing();
        clr_mon();
        playing = 1'b1;
        do_load(12, 1'b0);
        tests++; if ({err, s_ready, busy} !== 3'b100) begin fails++; $display("FAIL play_req: got err/ready/busy=%b required 100", {err, s_ready, busy}); end
        tick(); tick();
        tests++; if (wr_count != 0) begin fails++; $display("FAIL play_req_writes: got %0d required 0", wr_count); end
        playing = 1'b0;
        do_load(12, 1'b0);
        send_byte(8'hFF, 1'b0);
        tick();
        playing = 1'b1;
        tick();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL play_wr_en_drop: got %b required 0", wr_en); end
        tests++; if ({err, busy} !== 2'b10) begin fails++; $display("FAIL play_mid_state: got err/busy=%b required 10", {err, busy}); end
        playing = 1'b0;
        tick(); tick(); tick();
        tests++; if (wr_count != 2) begin fails++; $display("FAIL play_mid_writes: got %0d required 2", wr_count); end
    endtask

    task automatic test_full_depth();
        int bad = 0;
        logic [7:0] bv;
        clr_mon();
        do_load(256, 1'b1);
        for (int i = 0; i < 32; i++) send_byte(8'(i * 37 + 11), i == 31);
        wait_idle(40);
        for (int a = 0; a < 256; a++) begin
            bv = 8'((a / 8) * 37 + 11);
            if (!(wr_seen[a] == 1'b1 && wr_val[a] == bv[a % 8])) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL full_bits: got %0d wrong bits required 0", bad); end
        tests++; if (wr_count != 256 || last_addr != 255) begin fails++; $display("FAIL full_writes: got count=%0d last=%0d required 256/255", wr_count, last_addr); end
        tests++; if (len_out !== 9'd256 || len_at_done != 256) begin fails++; $display("FAIL full_len: got len_out=%0d at_done=%0d required 256", len_out, len_at_done); end
        tests++; if (done_count != 1 || trig_count != 1 || err !== 1'b0) begin fails++; $display("FAIL full_done: got done=%0d trig=%0d err=%b required 1/1/0", done_count, trig_count, err); end
    endtask

    task automatic test_abort();
        clr_mon();
        do_load(12, 1'b1);
        send_byte(8'hAA, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL abort_wr_en: got %b required 0", wr_en); end
        tests++; if ({busy, err, s_ready} !== 3'b000) begin fails++; $display("FAIL abort_state: got busy/err/ready=%b required 000", {busy, err, s_ready}); end
        tick(); tick();
        tests++; if (wr_count != 2 || done_count != 0) begin fails++; $display("FAIL abort_writes: got writes=%0d done=%0d required 2/0", wr_count, done_count); end
        tests++; if (len_out !== 9'd256) begin fails++; $display("FAIL abort_len_out: got %0d required 256", len_out); end
    endtask

    task automatic test_reset_mid_load();
        clr_mon();
        do_load(12, 1'b1);
        send_byte(8'h55, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        tests++; if ({s_ready, wr_en, wr_bit} !== 3'b000) begin fails++; $display("FAIL rstmid_port: got ready/wr_en/bit=%b required 000", {s_ready, wr_en, wr_bit}); end
        tests++; if (wr_addr !== '0) begin fails++; $display("FAIL rstmid_addr: got %0d required 0", wr_addr); end
        tests++; if (len_out !== '0) begin fails++; $display("FAIL rstmid_len_out: got %0d required 0", len_out); end
        tests++; if ({start_trig, busy, done, err} !== 4'b0) begin fails++; $display("FAIL rstmid_status: got %b required 0000", {start_trig, busy, done, err}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_illegal();
        test_early_last();
        test_backpressure();
        test_playing();
        test_full_depth();
        test_abort();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
